// File: rtl/reduce_pkg.sv
// Shared types and sizing helpers for the reduce_scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reduce_pkg;

  localparam int DEF_N          = 8;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  // Requester index width; a lone requester still needs one bit.
  function automatic int id_width(input int req);
    return (req > 1) ? $clog2(req) : 1;
  endfunction

  // Beat counter width, large enough to hold max_beats itself.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/reduce_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr, with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the grant.
// Ports: req (request vector), ptr (search start, must be < REQ),
//        gnt (one-hot grant, zero when no request), gnt_idx (grant index).
module rr_arbiter #(
  parameter int REQ = 4,
  parameter int IW  = 2
) (
  input  logic [REQ-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [REQ-1:0] gnt,
  output logic [IW-1:0]  gnt_idx
);

  // Walk the offsets from farthest to nearest so the nearest hit to ptr
  // is the last write and therefore wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = REQ - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % REQ)]) begin
        gnt                                 = '0;
        gnt[IW'((int'(ptr) + i) % REQ)]     = 1'b1;
        gnt_idx                             = IW'((int'(ptr) + i) % REQ);
      end
    end
  end

endmodule

// File: rtl/reduce_scheduler.sv
// Time-shares one N-lane adder tree among REQ requesters, one packet per grant,
// emitting one accumulated scalar per packet tagged with the requester id.
// Latency: out_valid 1+B cycles after the first valid beat in IDLE (B beats).
// Backpressure: req_ready only for the granted requester in ACCUM; the result
//   is held in OUTPUT until out_ready, during which no beats are accepted.
// Ports: clk, reset (sync, active-high); req_valid/req_last/req_vector/
//   req_ready per requester; out_valid/out_ready result handshake with
//   out_sum, out_id, out_beats, out_trunc (packet cut at MAX_BEATS).
// Build option REDUCE_SATURATE_EN: signed lanes, widened accumulation, out_sum
//   clamped to the signed DATA_WIDTH range, extra out_sat flag port.
module reduce_scheduler
  import reduce_pkg::*;
#(
  parameter int  N          = DEF_N,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  REQ        = 4,
  parameter int  MAX_BEATS  = 16,
  localparam int IW         = id_width(REQ),
  localparam int CW         = cnt_width(MAX_BEATS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [REQ-1:0]                        req_valid,
  input  logic [REQ-1:0]                        req_last,
  input  logic [REQ-1:0][N-1:0][DATA_WIDTH-1:0] req_vector,
  output logic [REQ-1:0]                        req_ready,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_sum,
  output logic [IW-1:0]                         out_id,
  output logic [CW-1:0]                         out_beats,
  output logic                                  out_trunc
`ifdef REDUCE_SATURATE_EN
  ,
  output logic                                  out_sat
`endif
);

`ifdef REDUCE_SATURATE_EN
  localparam int TW = DATA_WIDTH + $clog2(N);
  localparam int AW = DATA_WIDTH + $clog2(N * MAX_BEATS);
`else
  localparam int TW = DATA_WIDTH;
  localparam int AW = DATA_WIDTH;
`endif

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BEATS - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   g;
  logic [IW-1:0]   ptr;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            trunc;
  logic [REQ-1:0]  arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            xfer;
  logic            trunc_nxt;
  logic [TW-1:0]   tree_sum;
  logic [AW-1:0]   beat_ext;

  rr_arbiter #(.REQ(REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Shared adder tree, fed from the granted requester only.
  always_comb begin
    tree_sum = '0;
    for (int l = 0; l < N; l++) begin
`ifdef REDUCE_SATURATE_EN
      tree_sum = tree_sum + {{(TW-DATA_WIDTH){req_vector[g][l][DATA_WIDTH-1]}}, req_vector[g][l]};
`else
      tree_sum = tree_sum + req_vector[g][l];
`endif
    end
  end

`ifdef REDUCE_SATURATE_EN
  assign beat_ext = {{(AW-TW){tree_sum[TW-1]}}, tree_sum};
`else
  assign beat_ext = tree_sum;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    trunc_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|arb_gnt) state_nxt = ACCUM;
      end
      ACCUM: begin
        req_ready[g] = 1'b1;
        xfer         = req_valid[g];
        if (xfer) begin
          if (req_last[g]) begin
            state_nxt = OUTPUT;
          end else if (cnt == CNT_LAST) begin
            state_nxt = OUTPUT;
            trunc_nxt = 1'b1;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      acc   <= '0;
      cnt   <= '0;
      trunc <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |arb_gnt) g <= arb_idx;
      if (xfer) begin
        acc   <= (cnt == '0) ? beat_ext : acc + beat_ext;
        cnt   <= cnt + CW'(1);
        trunc <= trunc_nxt;
      end
      if (state == OUTPUT && out_ready) begin
        // Pointer moves past the served requester so it queues behind the rest.
        ptr   <= (g == IW'(REQ - 1)) ? '0 : g + IW'(1);
        acc   <= '0;
        cnt   <= '0;
        trunc <= 1'b0;
      end
    end
  end

  assign out_valid = (state == OUTPUT);
  assign out_id    = g;
  assign out_beats = cnt;
  assign out_trunc = trunc;

`ifdef REDUCE_SATURATE_EN
  localparam logic signed [AW-1:0] SMAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    out_sat = 1'b0;
    out_sum = acc[DATA_WIDTH-1:0];
    if ($signed(acc) > SMAX) begin
      out_sat = 1'b1;
      out_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if ($signed(acc) < SMIN) begin
      out_sat = 1'b1;
      out_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end
`else
  assign out_sum = acc;
`endif

endmodule

// File: tb/tb_reduce_scheduler.sv
// Self-checking bench for reduce_scheduler: directed cases plus randomized
// multi-requester traffic checked against a packet-level model.
module tb_reduce_scheduler;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int REQ = 4;
  localparam int MB  = 16;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct { vec_t v; bit last; } beat_t;
  typedef struct { logic [63:0] sum; int beats; bit trunc; bit sat; int id; } res_t;

  logic clk = 1'b0;
  logic reset;
  logic [REQ-1:0] req_valid, req_last, req_ready;
  logic [REQ-1:0][N-1:0][DW-1:0] req_vector;
  logic out_valid, out_ready, out_trunc;
  logic [DW-1:0] out_sum;
  logic [1:0] out_id;
  logic [4:0] out_beats;
`ifdef REDUCE_SATURATE_EN
  logic out_sat;
`endif

  reduce_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_vector(req_vector),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_id(out_id), .out_beats(out_beats), .out_trunc(out_trunc)
`ifdef REDUCE_SATURATE_EN
    , .out_sat(out_sat)
`endif
  );

  always #5 clk = ~clk;

  beat_t  bq[REQ][$];
  res_t   expq[REQ][$];
  res_t   logq[$];
  longint ms[REQ];
  int     mb[REQ];
  int     total = 0;
  int     bad = 0;
  int     vld_prob = 100;
  int     ordy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint lane_val(input logic [DW-1:0] x);
`ifdef REDUCE_SATURATE_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  // Close the model's open packet for requester r into its expected queue.
  task automatic finalize(input int r, input bit tr);
    res_t   e;
    longint s, hi, lo;
    s  = ms[r];
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    e.sat = 1'b0;
`ifdef REDUCE_SATURATE_EN
    if (s > hi) begin s = hi; e.sat = 1'b1; end
    else if (s < lo) begin s = lo; e.sat = 1'b1; end
`endif
    e.sum   = 64'(s & ((longint'(1) <<< DW) - 1));
    e.beats = mb[r];
    e.trunc = tr;
    e.id    = r;
    expq[r].push_back(e);
    ms[r] = 0;
    mb[r] = 0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int   mode;
    mode = $urandom_range(2);
    for (int l = 0; l < N; l++) begin
      if (mode == 0)      v[l] = DW'($urandom);
      else if (mode == 1) v[l] = DW'($urandom_range(15));
      else                v[l] = ($urandom_range(1) == 1) ? DW'(32'h7FFF_FFF0 + $urandom_range(15))
                                                          : DW'(32'h8000_0000 + $urandom_range(15));
    end
    return v;
  endfunction

  function automatic vec_t fill_vec(input logic [DW-1:0] x);
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = x;
    return v;
  endfunction

  task automatic push(input int r, input vec_t v, input bit last);
    beat_t b;
    b.v = v;
    b.last = last;
    bq[r].push_back(b);
  endtask

  // Requester and sink driver: inputs change 1 time unit after each rising edge.
  initial begin
    logic [REQ-1:0] acc_mask;
    req_valid = '0; req_last = '0; req_vector = '0; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc_mask = req_valid & req_ready & {REQ{~reset}};
      @(posedge clk);
      #1;
      for (int r = 0; r < REQ; r++)
        if (acc_mask[r]) void'(bq[r].pop_front());
      for (int r = 0; r < REQ; r++) begin
        if (bq[r].size() != 0 && int'($urandom_range(99)) < vld_prob) begin
          req_valid[r]  = 1'b1;
          req_vector[r] = bq[r][0].v;
          req_last[r]   = bq[r][0].last;
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
      out_ready = (ordy_mode == 0) ? 1'b1 : (ordy_mode == 2) ? 1'b0 : 1'($urandom_range(1));
    end
  end

  // Compare process: checks every presented result against the model and
  // folds every accepted beat into the model's per-requester packet state.
  initial begin
    res_t e;
    res_t a;
    for (int r = 0; r < REQ; r++) begin ms[r] = 0; mb[r] = 0; end
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int r = 0; r < REQ; r++) begin ms[r] = 0; mb[r] = 0; expq[r].delete(); end
        continue;
      end
      chk("ready_onehot0", 64'($countones(req_ready) <= 1), 64'd1);
      if (out_valid) begin
        if (expq[out_id].size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got id=%0d sum=0x%0h, expected no pending packet", out_id, out_sum);
        end else begin
          e = expq[out_id][0];
          chk("out_sum", 64'(out_sum), e.sum);
          chk("out_beats", 64'(out_beats), 64'(e.beats));
          chk("out_trunc", 64'(out_trunc), 64'(e.trunc));
`ifdef REDUCE_SATURATE_EN
          chk("out_sat", 64'(out_sat), 64'(e.sat));
          a.sat = out_sat;
`else
          a.sat = 1'b0;
`endif
          if (out_ready) begin
            void'(expq[out_id].pop_front());
            a.sum = 64'(out_sum); a.beats = int'(out_beats); a.trunc = out_trunc; a.id = int'(out_id);
            logq.push_back(a);
          end
        end
      end
      for (int r = 0; r < REQ; r++) begin
        if (req_valid[r] && req_ready[r]) begin
          for (int l = 0; l < N; l++) ms[r] += lane_val(req_vector[r][l]);
          mb[r]++;
          if (req_last[r]) finalize(r, 1'b0);
          else if (mb[r] == MB) finalize(r, 1'b1);
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int c;
    bit idle;
    c = 0;
    idle = 1'b0;
    forever begin
      @(negedge clk);
      idle = !out_valid && (req_ready == '0);
      for (int r = 0; r < REQ; r++)
        if (bq[r].size() != 0 || expq[r].size() != 0 || mb[r] != 0) idle = 1'b0;
      if (idle || c >= budget) break;
      c++;
    end
    chk({name, "_drain"}, 64'(idle), 64'd1);
  endtask

  task automatic measure(input int r, output int lat, output int rc);
    int w;
    w = 0; lat = 0; rc = 0;
    @(negedge clk);
    while (!req_valid[r] && w < 50) begin @(negedge clk); w++; end
    while (!out_valid && lat < 100) begin
      if (req_ready[r]) rc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_out_sum"}, 64'(out_sum), 64'd0);
    chk({tag, "_out_id"}, 64'(out_id), 64'd0);
    chk({tag, "_out_beats"}, 64'(out_beats), 64'd0);
    chk({tag, "_out_trunc"}, 64'(out_trunc), 64'd0);
`ifdef REDUCE_SATURATE_EN
    chk({tag, "_out_sat"}, 64'(out_sat), 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, rc, w;
    vec_t v;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);

    // Round-robin with every requester continuously valid.
    logq.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < REQ; r++) push(r, rand_vec(), 1'b1);
    drain("fair", 500);
    chk("fair_count", 64'(logq.size()), 64'd8);
    for (int i = 0; i < logq.size(); i++) chk("fair_id", 64'(logq[i].id), 64'(i % REQ));

    // Single beat, lanes 1..8 from requester 1.
    logq.delete();
    for (int l = 0; l < N; l++) v[l] = DW'(l + 1);
    push(1, v, 1'b1);
    measure(1, lat, rc);
    chk("t1_latency", 64'(lat), 64'd2);
    drain("t1", 100);
    chk("t1_count", 64'(logq.size()), 64'd1);
    if (logq.size() == 1) begin
      chk("t1_sum", logq[0].sum, 64'd36);
      chk("t1_id", 64'(logq[0].id), 64'd1);
      chk("t1_beats", 64'(logq[0].beats), 64'd1);
      chk("t1_trunc", 64'(logq[0].trunc), 64'd0);
    end

    // Three back-to-back beats of all fives from requester 0.
    logq.delete();
    for (int b = 0; b < 3; b++) push(0, fill_vec(DW'(5)), b == 2);
    measure(0, lat, rc);
    chk("t2_latency", 64'(lat), 64'd4);
    chk("t2_ready_cycles", 64'(rc), 64'd3);
    drain("t2", 100);
    chk("t2_count", 64'(logq.size()), 64'd1);
    if (logq.size() == 1) begin
      chk("t2_sum", logq[0].sum, 64'd120);
      chk("t2_beats", 64'(logq[0].beats), 64'd3);
    end

    // Twenty beats of ones with last only on beat 20: forced cut at 16.
    logq.delete();
    for (int b = 0; b < 20; b++) push(2, fill_vec(DW'(1)), b == 19);
    drain("trunc", 200);
    chk("trunc_count", 64'(logq.size()), 64'd2);
    if (logq.size() == 2) begin
      chk("trunc_p1_sum", logq[0].sum, 64'd128);
      chk("trunc_p1_beats", 64'(logq[0].beats), 64'd16);
      chk("trunc_p1_flag", 64'(logq[0].trunc), 64'd1);
      chk("trunc_p2_sum", logq[1].sum, 64'd32);
      chk("trunc_p2_beats", 64'(logq[1].beats), 64'd4);
      chk("trunc_p2_flag", 64'(logq[1].trunc), 64'd0);
    end

    // Result held for ten cycles with out_ready low.
    ordy_mode = 2;
    for (int l = 0; l < N; l++) v[l] = DW'(l + 1);
    push(1, v, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_sum", 64'(out_sum), 64'd36);
      chk("stall_id", 64'(out_id), 64'd1);
    end
    ordy_mode = 0;
    drain("stall", 100);

    // Reset in the middle of a packet from requester 3 (pointer is 2 here).
    logq.delete();
    for (int b = 0; b < 5; b++) push(3, fill_vec(DW'(3)), b == 4);
    w = 0;
    @(negedge clk);
    while (!(req_valid[3] && req_ready[3]) && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1 reset = 1'b1;
    push(1, fill_vec(DW'(2)), 1'b1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_zero_outputs("midreset");
    drain("midreset", 200);
    chk("midreset_count", 64'(logq.size()), 64'd2);
    if (logq.size() == 2) begin
      chk("midreset_first_id", 64'(logq[0].id), 64'd1);
      chk("midreset_first_sum", logq[0].sum, 64'd16);
      chk("midreset_second_id", 64'(logq[1].id), 64'd3);
      chk("midreset_second_sum", logq[1].sum, 64'd96);
      chk("midreset_second_beats", 64'(logq[1].beats), 64'd4);
    end

    // Lane extremes.
    logq.delete();
    push(0, fill_vec(32'hFFFF_FFFF), 1'b1);
    drain("wrap", 100);
    if (logq.size() >= 1) chk("wrap_sum", logq[0].sum, 64'hFFFF_FFF8);
    else chk("wrap_count", 64'(logq.size()), 64'd1);
`ifdef REDUCE_SATURATE_EN
    logq.delete();
    push(0, fill_vec(32'h7FFF_FFFF), 1'b1);
    drain("sat", 100);
    chk("sat_count", 64'(logq.size()), 64'd1);
    if (logq.size() == 1) begin
      chk("sat_sum", logq[0].sum, 64'h7FFF_FFFF);
      chk("sat_flag", 64'(logq[0].sat), 64'd1);
    end
`endif

    // Randomized traffic with sporadic valid and out_ready.
    vld_prob = 70;
    ordy_mode = 1;
    repeat (120) begin
      int r, len;
      bit lastok;
      r = $urandom_range(REQ - 1);
      len = $urandom_range(20, 1);
      lastok = ($urandom_range(9) != 0);
      for (int b = 0; b < len; b++) push(r, rand_vec(), (b == len - 1) && lastok);
    end
    for (int r = 0; r < REQ; r++) push(r, rand_vec(), 1'b1);
    drain("random", 30000);
    vld_prob = 100;
    ordy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reduce_scheduler.md
Name: reduce_scheduler

Overview:
- Time-shares one combinational N-lane adder tree between REQ requesters.
- Each requester streams a vector as one or more N-lane beats. The block arbitrates round-robin per packet and feeds each granted beat to the tree.
- It accumulates the per-beat sums into one scalar per packet and emits that scalar with the requester ID.
- It sits between the per-core filter/reduction stages and the trace buffer write path.

Parameters:
- N, 8, lanes per beat; width of the adder tree; must be >= 2.
- DATA_WIDTH, 32, lane and sum width in bits.
- REQ, 4, number of requesters; must be >= 2.
- MAX_BEATS, 16, maximum beats per packet before forced termination.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  REQ  per-requester beat valid.
- req_last  in  REQ  per-requester last-beat-of-packet flag.
- req_vector  in  REQ x N x DATA_WIDTH  per-requester beat lanes.
- req_ready  out  REQ  per-requester beat accept; at most one bit high.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_sum  out  DATA_WIDTH  packet sum.
- out_id  out  $clog2(REQ)  requester index of the packet.
- out_beats  out  $clog2(MAX_BEATS+1)  beats accumulated.
- out_trunc  out  1  packet force-ended at MAX_BEATS without last.

Behaviour:
- Reset: state=IDLE, req_ready=0, out_valid=0, out_sum/out_id/out_beats/out_trunc=0, rr pointer=0, accumulator=0, beat count=0. A reset mid-packet discards the partial sum; requesters re-present their beats.
- IDLE:
  - Grant the first requester with req_valid=1, searching from the rr pointer upward with wrap.
  - Register grant g and go to ACCUM.
  - No valid requester: stay in IDLE.
  - Costs one cycle; req_ready=0 in IDLE.
- ACCUM:
  - req_ready[g]=1; all other bits 0.
  - A beat transfers when req_valid[g] & req_ready[g].
  - On a transfer: tree_sum = sum of the N lanes of req_vector[g], modulo 2^DATA_WIDTH. acc <= (beat count==0 ? tree_sum : acc+tree_sum). Beat count increments.
  - A transfer with req_last[g]=1 goes to OUTPUT with out_trunc=0.
  - A transfer that makes beat count==MAX_BEATS without last goes to OUTPUT with out_trunc=1. The requester's following beats start a new packet.
  - req_valid[g] deasserting mid-packet stalls ACCUM; there is no timeout.
- OUTPUT:
  - out_valid=1; out_sum=acc, out_id=g, out_beats and out_trunc are held stable until out_ready.
  - On out_valid & out_ready: rr pointer <= (g+1) mod REQ, acc and beat count cleared, go to IDLE.
  - req_ready is all 0 in OUTPUT.
- Latency: from the first valid beat in IDLE, out_valid is asserted 1 + B cycles later for B beats (back-to-back valid). Throughput is one beat per cycle in ACCUM.
- Fairness: a continuously requesting source is re-granted only after every other pending source has had one packet.
- Adder tree: combinational, with no pipeline registers. A tree-output register is not included.
- Arithmetic: all sums wrap modulo 2^DATA_WIDTH unless the optional feature is enabled.

Optional Feature:
- Macro REDUCE_SATURATE_EN.
- Defined:
  - Lanes are treated as signed two's complement.
  - The per-beat tree sum is computed at DATA_WIDTH+$clog2(N) bits.
  - The accumulator is DATA_WIDTH+$clog2(N*MAX_BEATS) bits wide.
  - out_sum is clamped to the signed DATA_WIDTH range [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - An extra output port out_sat (1 bit) is high when clamping occurred; reset value 0.
- Undefined: modulo wrap; out_sat port absent.

Decomposition:
- Shared package reduce_pkg holds:
  - state enum (IDLE, ACCUM, OUTPUT);
  - localparam functions for ID width and beat-count width;
  - default N/DATA_WIDTH constants.
- Sub-module rr_arbiter (REQ, request vector, pointer in, one-hot grant plus index out, combinational).
- Adder tree instantiated once; not part of this block's RTL.

Test Plan:
- Single requester 1, one beat, lanes 1..8, last=1 -> 2 cycles later out_valid, out_sum=36, out_id=1, out_beats=1, out_trunc=0.
- Requester 0, 3 beats of all-lanes=5, back-to-back, last on beat 3 -> out_sum=120, out_beats=3; req_ready[0] high exactly 3 cycles.
- All 4 requesters valid continuously, 1-beat packets -> out_id sequence 0,1,2,3,0,1,... with no source granted twice in any 4 consecutive packets.
- Requester 2 streams 20 beats of all-lanes=1, no last until beat 20 -> packet 1: out_sum=128, out_beats=16, out_trunc=1; packet 2: out_sum=32, out_beats=4, out_trunc=0.
- out_ready held 0 for 10 cycles in OUTPUT -> out_* stable, req_ready all 0; reset asserted mid-ACCUM -> next cycle all outputs 0, state IDLE, rr pointer 0.
- Lanes 0xFFFFFFFF x 8, one beat -> wrap: out_sum=0xFFFFFFF8. With REDUCE_SATURATE_EN, lanes 0x7FFFFFFF x 8 -> out_sum=0x7FFFFFFF, out_sat=1.
